// File: rtl/bicubic_pkg.sv
// Shared widths, FSM state type and window slot mapping for the bicubic window fetcher.
package bicubic_pkg;

    localparam int PIX_W   = 8;
    localparam int COORD_W = 7;
    localparam int ADDR_W  = 14;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Window slot of row r, column c: r*4+c, which is just {r, c} for 2-bit indices.
    function automatic logic [3:0] slot_idx(input logic [1:0] r, input logic [1:0] c);
        return {r, c};
    endfunction

endpackage

// File: rtl/bicubic_coord_clamp.sv
// Clamps base+offset into 0..dim-1 using signed arithmetic two bits wider than a coordinate.
module bicubic_coord_clamp
    import bicubic_pkg::*;
(
    input  logic [COORD_W-1:0] base,
    input  logic [2:0]         off,    // two's complement tap offset, -1..2
    input  logic [COORD_W-1:0] dim,    // 1..100
    output logic [COORD_W-1:0] idx
);
    localparam int SW = COORD_W + 2;

    logic signed [SW-1:0] pos;
    logic signed [SW-1:0] lim;

    assign pos = $signed({2'b00, base}) + $signed({{(SW-3){off[2]}}, off});
    assign lim = $signed({2'b00, dim}) - $signed(SW'(1));

    // Saturate below at zero and above at the last valid index.
    always_comb begin
        if (pos < 0) begin
            idx = '0;
        end else if (pos > lim) begin
            idx = lim[COORD_W-1:0];
        end else begin
            idx = pos[COORD_W-1:0];
        end
    end

endmodule

// File: rtl/bicubic_window_fetch.sv
// Fetches a clamped 4x4 pixel neighbourhood from a single-port ROM and holds it
// behind a valid/ready handshake; a one-column step on the same row refetches only column 3.
module bicubic_window_fetch
    import bicubic_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COORD_W-1:0]    cx,
    input  logic [COORD_W-1:0]    cy,
    input  logic [COORD_W-1:0]    img_w,
    input  logic [COORD_W-1:0]    img_h,
    output logic                  busy,
    output logic                  rom_rd,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [PIX_W-1:0]      rom_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [16*PIX_W-1:0]   win_pix
);
    state_t               state_q, state_d;
    logic [3:0]           k_q, k_d;
    logic                 slide_q;       // a completed window exists to slide from
    logic                 slide_mode_q;  // current fetch is a 4-read column refill
    logic [COORD_W-1:0]   cx_q, cy_q, w_q, h_q;
    logic                 cap_en_q;
    logic [3:0]           cap_slot_q;
    logic [PIX_W-1:0]     win_q [16];

    logic                 accept;
    logic                 slide_hit;
    logic [3:0]           k_last;
    logic [1:0]           iss_r, iss_c;
    logic [COORD_W-1:0]   x_idx, y_idx;
    logic [ADDR_W-1:0]    addr;

    assign accept    = (state_q == IDLE) && start;
    assign slide_hit = slide_q && (cy == cy_q) && (img_w == w_q) && (img_h == h_q)
                       && ({1'b0, cx} == ({1'b0, cx_q} + 1'b1));
    assign k_last    = slide_mode_q ? 4'd3 : 4'd15;

    // Issue k maps row-major for a full fetch, or down column 3 for a slide.
    assign iss_r = slide_mode_q ? k_q[1:0] : k_q[3:2];
    assign iss_c = slide_mode_q ? 2'd3     : k_q[1:0];

    bicubic_coord_clamp u_clamp_x (
        .base (cx_q),
        .off  (3'({1'b0, iss_c}) - 3'd1),
        .dim  (w_q),
        .idx  (x_idx)
    );

    bicubic_coord_clamp u_clamp_y (
        .base (cy_q),
        .off  (3'({1'b0, iss_r}) - 3'd1),
        .dim  (h_q),
        .idx  (y_idx)
    );

    assign addr = ADDR_W'(y_idx) * ADDR_W'(w_q) + ADDR_W'(x_idx);

    assign busy      = (state_q != IDLE);
    assign rom_rd    = (state_q == FETCH);
    assign rom_addr  = rom_rd ? addr : '0;
    assign win_valid = (state_q == HOLD);

    // Next-state and read counter sequencing.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    k_d     = 4'd0;
                end
            end
            FETCH: begin
                k_d = k_q + 4'd1;
                if (k_q == k_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (win_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers: state, counter, request latch and slide bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            k_q          <= '0;
            slide_q      <= 1'b0;
            slide_mode_q <= 1'b0;
            cx_q         <= '0;
            cy_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (accept) begin
                slide_mode_q <= slide_hit;
                cx_q         <= cx;
                cy_q         <= cy;
                w_q          <= img_w;
                h_q          <= img_h;
            end
            if (state_q == DRAIN) begin
                slide_q <= 1'b1;
            end
        end
    end

    // Window store: returned data lands in the slot of the read issued one cycle earlier;
    // an accepted slide shifts columns 1..3 left before column 3 is refetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_en_q   <= 1'b0;
            cap_slot_q <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            cap_en_q   <= rom_rd;
            cap_slot_q <= slot_idx(iss_r, iss_c);
            if (cap_en_q) begin
                win_q[cap_slot_q] <= rom_data;
            end
            if (accept && slide_hit) begin
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        win_q[r*4+c] <= win_q[r*4+c+1];
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pack
            assign win_pix[gi*PIX_W +: PIX_W] = win_q[gi];
        end
    endgenerate

endmodule
